// File: rtl/adc_model_pkg.sv
// Shared encodings for the serial-ADC slave model: mode codes, FSM states and
// the noise LFSR polynomial/seed.
package adc_model_pkg;

    localparam logic [1:0] MODE_TONE  = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_TAIL,
        ST_DONE
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15/13/12/10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM with quadrant folding; one-cycle registered output in
// offset binary.
module sine_quarter_lut #(
    parameter int SAMPLE_W = 12,
    parameter int PHASE_W  = 16,
    parameter int LUT_W    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PHASE_W-1:0]  phase_i,
    output logic [SAMPLE_W-1:0] sample_o
);

    localparam int  DEPTH   = 1 << LUT_W;
    localparam int  MID     = 1 << (SAMPLE_W - 1);
    localparam real AMP     = real'(MID - 1);
    localparam real HALF_PI = 1.5707963267948966;

    logic [SAMPLE_W-2:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam int VAL = $rtoi(AMP * $sin(HALF_PI * real'(g) / real'(DEPTH)) + 0.5);
        assign rom[g] = (SAMPLE_W-1)'(VAL);
    end

    logic [1:0]          quad;
    logic [LUT_W-1:0]    idx;
    logic [SAMPLE_W-2:0] amp;
    logic [SAMPLE_W-1:0] sample_d;
    logic                unused_bits;

    assign unused_bits = ^phase_i;

    always_comb begin
        quad = phase_i[PHASE_W-1 -: 2];
        idx  = phase_i[PHASE_W-3 -: LUT_W];
        if (quad[0]) begin
            idx = ~idx;
        end
        amp = rom[idx];
        if (quad[1]) begin
            sample_d = SAMPLE_W'(MID) - {1'b0, amp};
        end else begin
            sample_d = SAMPLE_W'(MID) + {1'b0, amp};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_o <= '0;
        end else begin
            sample_o <= sample_d;
        end
    end

endmodule

// File: rtl/adc_tone_model.sv
// Serial-ADC slave model: tone/ramp/constant samples, round-robin channels,
// optional sample limit. Define ADC_MODEL_NOISE_EN to add LFSR dither.
//   state    | meaning
//   ST_IDLE  | sd low, waiting for cs fall
//   ST_SHIFT | null bits then sample bits, one per adc_clk fall
//   ST_TAIL  | sd low, cs rise completes the conversion
//   ST_DONE  | sample limit reached, cs ignored until run drops
module adc_tone_model
    import adc_model_pkg::*;
#(
    parameter int SAMPLE_W    = 12,
    parameter int CHANNELS    = 1,
    parameter int NULL_BITS   = 2,
    parameter int PHASE_W     = 16,
    parameter int LUT_W       = 8,
    parameter int NUM_SAMPLES = 0,
    parameter int NOISE_BITS  = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          run,
    input  logic [1:0]                    mode,
    input  logic [SAMPLE_W-1:0]           const_code,
    input  logic [CHANNELS*PHASE_W-1:0]   phase_inc,
    input  logic                          adc_cs,
    input  logic                          adc_clk,
    output logic                          adc_sd,
    output logic                          done,
    output logic [31:0]                   sample_count,
    output logic [$clog2(CHANNELS):0]     channel
);

    localparam int TOT  = NULL_BITS + SAMPLE_W;
    localparam int BC_W = $clog2(TOT + 1);
    localparam int CH_W = $clog2(CHANNELS) + 1;
    localparam int SW   = SAMPLE_W + 2;

    logic [1:0] cs_sync_q, ck_sync_q;
    logic       cs_dly_q, ck_dly_q;
    logic       cs_fall, cs_rise, ck_fall;

    state_e              state_q, state_d;
    logic [TOT-1:0]      shift_q, shift_d;
    logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
    logic                sd_q, sd_d;
    logic [31:0]         count_q, count_d;
    logic                done_q, done_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic [PHASE_W-1:0]  phase_q [CHANNELS];
    logic [PHASE_W-1:0]  phase_d [CHANNELS];
    logic                complete;

    logic [PHASE_W-1:0]  cur_phase;
    logic [SAMPLE_W-1:0] tone_code, base, cand_d, cand_q;
    logic [NOISE_BITS:0] noise;
    logic [SW-1:0]       noisy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q <= '0;
            ck_sync_q <= '0;
            cs_dly_q  <= 1'b0;
            ck_dly_q  <= 1'b0;
        end else begin
            cs_sync_q <= {cs_sync_q[0], adc_cs};
            ck_sync_q <= {ck_sync_q[0], adc_clk};
            cs_dly_q  <= cs_sync_q[1];
            ck_dly_q  <= ck_sync_q[1];
        end
    end

    assign cs_fall = cs_dly_q & ~cs_sync_q[1];
    assign cs_rise = ~cs_dly_q & cs_sync_q[1];
    assign ck_fall = ck_dly_q & ~ck_sync_q[1];

    always_comb begin
        cur_phase = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan_q == CH_W'(c)) begin
                cur_phase = phase_q[c];
            end
        end
    end

    sine_quarter_lut #(
        .SAMPLE_W (SAMPLE_W),
        .PHASE_W  (PHASE_W),
        .LUT_W    (LUT_W)
    ) u_lut (
        .clk      (clk),
        .reset_n  (reset_n),
        .phase_i  (cur_phase),
        .sample_o (tone_code)
    );

`ifdef ADC_MODEL_NOISE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (complete) begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign noise = lfsr_q[NOISE_BITS:0];
`else
    assign noise = '0;
`endif

    // noise is two's complement; bit SW-1 flags underflow, bit SW-2 overflow
    always_comb begin
        case (mode)
            MODE_TONE: base = tone_code;
            MODE_RAMP: base = cur_phase[PHASE_W-1 -: SAMPLE_W];
            default:   base = const_code;
        endcase
        noisy = {2'b00, base} + SW'($signed(noise));
        if (noisy[SW-1]) begin
            cand_d = '0;
        end else if (noisy[SW-2]) begin
            cand_d = '1;
        end else begin
            cand_d = noisy[SAMPLE_W-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        sd_d     = sd_q;
        count_d  = count_q;
        done_d   = done_q;
        chan_d   = chan_q;
        phase_d  = phase_q;
        complete = 1'b0;

        if (!run) begin
            state_d = ST_IDLE;
            sd_d    = 1'b0;
            count_d = '0;
            done_d  = 1'b0;
            chan_d  = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                phase_d[c] = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sd_d = 1'b0;
                    if (cs_fall && !done_q) begin
                        shift_d  = TOT'(cand_q);
                        bitcnt_d = '0;
                        state_d  = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        sd_d    = 1'b0;
                        state_d = ST_IDLE;
                    end else if (ck_fall) begin
                        sd_d     = shift_q[TOT-1];
                        shift_d  = shift_q << 1;
                        bitcnt_d = bitcnt_q + BC_W'(1);
                        if (bitcnt_q == BC_W'(TOT - 1)) begin
                            state_d = ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    if (cs_rise) begin
                        complete = 1'b1;
                    end else if (ck_fall) begin
                        sd_d = 1'b0;
                    end
                end
                default: begin
                    sd_d = 1'b0;
                end
            endcase

            if (complete) begin
                sd_d    = 1'b0;
                count_d = count_q + 32'd1;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (chan_q == CH_W'(c)) begin
                        phase_d[c] = phase_q[c] + phase_inc[c*PHASE_W +: PHASE_W];
                    end
                end
                chan_d = (chan_q == CH_W'(CHANNELS - 1)) ? '0 : chan_q + CH_W'(1);
                if ((NUM_SAMPLES != 0) && (count_d == 32'(NUM_SAMPLES))) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            sd_q     <= 1'b0;
            count_q  <= '0;
            done_q   <= 1'b0;
            chan_q   <= '0;
            cand_q   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                phase_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            sd_q     <= sd_d;
            count_q  <= count_d;
            done_q   <= done_d;
            chan_q   <= chan_d;
            cand_q   <= cand_d;
            phase_q  <= phase_d;
        end
    end

    assign adc_sd       = sd_q;
    assign done         = done_q;
    assign sample_count = count_q;
    assign channel      = chan_q;

endmodule

// File: doc/adc_tone_model.md
# adc_tone_model

Parametrised, synthesisable serial-ADC slave model for the waterfall badge benches and on-board self-test. It answers the ADC master's chip-select/serial-clock protocol with a stream of offset-binary samples, which are tone (sine), ramp or constant codes. Multiple channels are served round-robin, and a finite sample count can raise `done`. It replaces the fixed single-tone model and sits between the top-level ADC pins and the stimulus or loopback logic.

## Interface
- `SAMPLE_W`, 12: sample width in bits.
- `CHANNELS`, 1: number of channels, each with its own phase accumulator.
- `NULL_BITS`, 2: leading zero bits before the sample MSB.
- `PHASE_W`, 16: phase accumulator width.
- `LUT_W`, 8: log2 of the quarter-wave LUT depth.
- `NUM_SAMPLES`, 0: completed conversions before `done`; 0 means unlimited.
- `NOISE_BITS`, 2: noise magnitude width; used only with the noise macro.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  enable; when low, clears the count, `done`, all phases and the channel.
- `mode`  in  2  0 = tone, 1 = ramp, 2 = constant, 3 = reserved (treated as constant).
- `const_code`  in  SAMPLE_W  code returned in constant mode.
- `phase_inc`  in  CHANNELS*PHASE_W  per-channel increment; channel 0 occupies the LSBs.
- `adc_cs`  in  1  active-low chip select from the master.
- `adc_clk`  in  1  serial clock from the master.
- `adc_sd`  out  1  serial data, MSB first.
- `done`  out  1  level; target sample count reached.
- `sample_count`  out  32  completed conversions.
- `channel`  out  $clog2(CHANNELS)+1  channel of the next or current conversion.

All outputs reset to 0.

## Operation
- `adc_cs` and `adc_clk` each pass through a 2-flop synchroniser, followed by an edge-detect register.
- States:
  - IDLE: `adc_sd` = 0. On a cs fall with `run` high and `done` low, latch `sample` and go to SHIFT.
  - SHIFT: count adc_clk falling edges k, starting at 1.
    - k ≤ NULL_BITS: sd = 0.
    - NULL_BITS < k ≤ NULL_BITS+SAMPLE_W: sd = sample[SAMPLE_W-1-(k-NULL_BITS-1)].
    - After the LSB has been driven, go to TAIL.
  - TAIL: sd = 0. A cs rise completes the conversion and returns to IDLE.
  - DONE: sd = 0 and cs is ignored. Exit only when `run` goes low.
- Conversion complete, in a single cycle:
  - `sample_count`++.
  - phase[channel] += phase_inc[channel], modulo 2^PHASE_W.
  - `channel` advances, wrapping at CHANNELS-1 back to 0.
  - If `sample_count` reaches NUM_SAMPLES (nonzero), set `done` and enter DONE.
- Abort: a cs rise while in SHIFT returns to IDLE and drives sd = 0. Count, phase and channel are unchanged, so the next conversion repeats the same sample.
- Sample source, from the current channel's phase p:
  - Tone:
    - Quadrant is q = p[MSB:MSB-1] and index is i = p[MSB-2 -: LUT_W].
    - For q = 1 or 3, the index is mirrored (~i).
    - LUT[i] = round((2^(SAMPLE_W-1)-1)·sin(π/2·i/2^LUT_W)).
    - Output is 2^(SAMPLE_W-1) + amplitude for q = 0/1, and 2^(SAMPLE_W-1) − amplitude for q = 2/3.
  - Ramp: p[PHASE_W-1 -: SAMPLE_W].
  - Constant: `const_code`.
- The candidate sample is registered every cycle, so it is always valid when cs falls.
- `run` low overrides every state: go to IDLE and clear count, `done`, phases and channel.

## Timing
- `adc_sd` changes 3 clk cycles after an adc_clk fall at the pin. The same 3-cycle latency applies from a cs fall to sample latch.
- Each adc_clk half-period must be at least 4 clk cycles. Behaviour below that is undefined.
- Simultaneous adc_clk fall and cs rise: the cs rise wins.
- Completion updates become visible one cycle after the synchronised cs rise.
- `reset_n` asserted mid-conversion forces IDLE and sd = 0 immediately, without waiting for a clock.

## Configuration
- `ADC_MODEL_NOISE_EN` defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1) advances once per completed conversion.
  - Its low NOISE_BITS+1 bits, read as two's complement, are added to every sample.
  - The result saturates to [0, 2^SAMPLE_W-1].
- Undefined: no LFSR is built, samples are exact, and NOISE_BITS is ignored.

## Structure
- Package `adc_model_pkg` holds:
  - the mode encoding constants;
  - the state enum;
  - the LFSR taps and seed.
- Sub-module `sine_quarter_lut`: combinational ROM generated from SAMPLE_W/LUT_W, registered output, with the quadrant folding handled inside.

## Test plan
- Constant 0xA5C, SAMPLE_W=12, NULL_BITS=2, one 16-clock conversion -> sd sequence 0,0,1,0,1,0,0,1,0,1,1,1,0,0,0,0; `sample_count` = 1.
- Tone, phase_inc=0x4000, four conversions -> samples 2048, 4095, 2048, 1; the fifth conversion returns 2048.
- CHANNELS=2, ramp, inc 0x0100/0x0200 -> `channel` alternates 0,1,0. Samples are 0x000, 0x000, 0x010, 0x020.
- Abort after 5 adc_clk falls -> `sample_count` unchanged. The next full conversion returns the identical code.
- NUM_SAMPLES=3 -> `done` rises after the third cs rise, and a fourth cs fall gives sd = 0 throughout. `run` low then high clears `done` and the count.
- `reset_n` pulsed low during the data bits -> sd = 0 asynchronously and all outputs 0. After release, a full conversion succeeds and returns phase-0 data.
